// File: rtl/phase_timer_sequencer_if.sv
// rtl/phase_timer_sequencer_if.sv - link between the phase sequencer and the interval counter
interface phase_timer_sequencer_if #(
  parameter int W = 8
);
  logic         timer_clr_o;
  logic         timer_load_o;
  logic [W-1:0] timer_value_o;
  logic         timer_en_o;
  logic         timer_done_i;

  modport master (
    output timer_clr_o,
    output timer_load_o,
    output timer_value_o,
    output timer_en_o,
    input  timer_done_i
  );

  modport slave (
    input  timer_clr_o,
    input  timer_load_o,
    input  timer_value_o,
    input  timer_en_o,
    output timer_done_i
  );
endinterface

// File: rtl/phase_timer_sequencer.sv
// rtl/phase_timer_sequencer.sv - steps an interval counter through a table of phase durations
module phase_timer_sequencer #(
  parameter int           N_PHASES = 4,
  parameter int           W        = 8,
  parameter logic [W-1:0] DEF_DUR  = W'(8'h0a),
  localparam int          AW       = $clog2(N_PHASES)
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    pause_i,
  input  logic                    loop_i,
  input  logic                    cfg_we_i,
  input  logic [AW-1:0]           cfg_addr_i,
  input  logic [W-1:0]            cfg_data_i,
  output logic                    cfg_err_o,
  phase_timer_sequencer_if.master tmr,
  output logic                    busy_o,
  output logic [AW-1:0]           phase_o,
  output logic                    phase_tick_o,
  output logic                    seq_done_o
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_LOAD, S_RUN} state_t;

  state_t         state, next_state;
  logic [W-1:0]   table_q [N_PHASES];

  logic           last_phase;
  logic           aborting;
  logic           done_seen;
  logic           finishing;
  logic           wr_bad_addr;
  logic           wr_busy_hit;

  logic           clr_d, load_d, busy_d, tick_d, seq_done_d;
  logic [W-1:0]   value_d;
  logic [AW-1:0]  phase_d;

  assign last_phase  = (phase_o == AW'(N_PHASES - 1));
  // stop outranks everything, including a coincident end-of-count
  assign aborting    = stop_i && (state != S_IDLE);
  assign done_seen   = (state == S_RUN) && tmr.timer_done_i && !stop_i;
  assign finishing   = done_seen && last_phase && !loop_i;
  assign wr_bad_addr = (int'(cfg_addr_i) >= N_PHASES);
  assign wr_busy_hit = (state != S_IDLE) && (cfg_addr_i == phase_o);

  // Count enable stays combinational so the counter stops in the very cycle done is seen
  assign tmr.timer_en_o = (state == S_RUN) && !pause_i && !tmr.timer_done_i;

  // State register plus the registered outputs
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state             <= S_IDLE;
      phase_o           <= '0;
      busy_o            <= 1'b0;
      phase_tick_o      <= 1'b0;
      seq_done_o        <= 1'b0;
      tmr.timer_clr_o   <= 1'b0;
      tmr.timer_load_o  <= 1'b0;
      tmr.timer_value_o <= '0;
    end else begin
      state             <= next_state;
      phase_o           <= phase_d;
      busy_o            <= busy_d;
      phase_tick_o      <= tick_d;
      seq_done_o        <= seq_done_d;
      tmr.timer_clr_o   <= clr_d;
      tmr.timer_load_o  <= load_d;
      tmr.timer_value_o <= value_d;
    end
  end

  // Next-state decision
  always_comb begin
    next_state = state;
    if (aborting) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start_i && !stop_i) next_state = S_CLEAR;
        S_CLEAR: next_state = S_LOAD;
        S_LOAD:  next_state = S_RUN;
        S_RUN:   if (done_seen) next_state = finishing ? S_IDLE : S_CLEAR;
        default: next_state = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs
  always_comb begin
    clr_d      = aborting || (next_state == S_CLEAR);
    load_d     = (next_state == S_LOAD);
    value_d    = (next_state == S_LOAD) ? table_q[phase_o] : tmr.timer_value_o;
    busy_d     = (next_state != S_IDLE);
    tick_d     = done_seen;
    seq_done_d = finishing;
    phase_d    = phase_o;
    if (aborting) begin
      phase_d = '0;
    end else if ((state == S_IDLE) && start_i && !stop_i) begin
      phase_d = '0;
    end else if (done_seen && !finishing) begin
      phase_d = last_phase ? '0 : phase_o + AW'(1);
    end
  end

  // Duration table writes; the entry in use is protected while a sequence runs
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      cfg_err_o <= 1'b0;
      for (int i = 0; i < N_PHASES; i++) begin
        table_q[i] <= DEF_DUR;
      end
    end else begin
      cfg_err_o <= cfg_we_i && (wr_bad_addr || wr_busy_hit);
      if (cfg_we_i && !wr_bad_addr && !wr_busy_hit) begin
        table_q[cfg_addr_i] <= cfg_data_i;
      end
    end
  end

endmodule

// File: tb/tb_phase_timer_sequencer.sv
// tb/tb_phase_timer_sequencer.sv - directed self-checking bench for phase_timer_sequencer
module tb_phase_timer_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic       cfg_err, busy, tick, seq_done;
  logic [1:0] phase;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_tick = 0;
  int n_done = 0;

  phase_timer_sequencer_if #(.W(8)) tmr_if ();

  phase_timer_sequencer #(.N_PHASES(4), .W(8), .DEF_DUR(8'h0a)) dut (
    .clk          (clk),
    .rst_i        (rst),
    .start_i      (start),
    .stop_i       (stop),
    .pause_i      (pause),
    .loop_i       (loop_en),
    .cfg_we_i     (cfg_we),
    .cfg_addr_i   (cfg_addr),
    .cfg_data_i   (cfg_data),
    .cfg_err_o    (cfg_err),
    .tmr          (tmr_if),
    .busy_o       (busy),
    .phase_o      (phase),
    .phase_tick_o (tick),
    .seq_done_o   (seq_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tick) n_tick <= n_tick + 1;
    if (seq_done) n_done <= n_done + 1;
  end

  // Interval counter: clear beats load, ends after value+1 enabled cycles, done registered
  logic [7:0] cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      tmr_if.timer_done_i <= 1'b0;
    end else if (tmr_if.timer_clr_o) begin
      cnt <= '0;
      tmr_if.timer_done_i <= 1'b0;
    end else if (tmr_if.timer_load_o) begin
      cnt <= tmr_if.timer_value_o;
      tmr_if.timer_done_i <= 1'b0;
    end else if (tmr_if.timer_en_o) begin
      if (cnt == 8'd0) begin
        tmr_if.timer_done_i <= 1'b1;
      end else begin
        cnt <= cnt - 8'd1;
        tmr_if.timer_done_i <= 1'b0;
      end
    end else begin
      tmr_if.timer_done_i <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_start(output int t0);
    start = 1'b1;
    step();
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic wait_tick(input string tag, output int at);
    int n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 200);
    if (!tick) chk({tag, "_timeout"}, 32'd0, 32'd1);
    at = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, t, d0;
    logic [2:0] far_addr;

    // reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_phase", phase, 0);
    chk("rst_clr", tmr_if.timer_clr_o, 0);
    chk("rst_load", tmr_if.timer_load_o, 0);
    chk("rst_value", tmr_if.timer_value_o, 0);
    chk("rst_en", tmr_if.timer_en_o, 0);
    step();
    step();
    rst = 1'b0;
    step();

    // one-shot sequence with table {2,3,1,0}
    cfg_write(2'd0, 8'd2); chk("w0_err", cfg_err, 0);
    cfg_write(2'd1, 8'd3);
    cfg_write(2'd2, 8'd1);
    cfg_write(2'd3, 8'd0);
    d0 = n_done;
    do_start(t0);
    chk("os_clear", tmr_if.timer_clr_o, 1);
    chk("os_busy", busy, 1);
    chk("os_phase0", phase, 0);
    step();
    chk("os_load", tmr_if.timer_load_o, 1);
    chk("os_value", tmr_if.timer_value_o, 2);
    chk("os_clr_off", tmr_if.timer_clr_o, 0);
    wait_tick("os_t1", t); chk("os_t1_at", t - t0, 6);  chk("os_t1_ph", phase, 1);
    wait_tick("os_t2", t); chk("os_t2_at", t - t0, 13); chk("os_t2_ph", phase, 2);
    wait_tick("os_t3", t); chk("os_t3_at", t - t0, 18); chk("os_t3_ph", phase, 3);
    chk("os_nodone_early", n_done - d0, 0);
    wait_tick("os_t4", t); chk("os_t4_at", t - t0, 22);
    chk("os_seq_done", seq_done, 1);
    chk("os_busy_fall", busy, 0);
    chk("os_phase_hold", phase, 3);
    step();
    chk("os_done_pulse", seq_done, 0);

    // looping sequence ended by stop
    loop_en = 1'b1;
    d0 = n_done;
    do_start(t0);
    wait_tick("lp_t1", t);
    wait_tick("lp_t2", t);
    wait_tick("lp_t3", t);
    wait_tick("lp_t4", t); chk("lp_t4_at", t - t0, 22);
    chk("lp_wrap_phase", phase, 0);
    chk("lp_reclear", tmr_if.timer_clr_o, 1);
    chk("lp_busy", busy, 1);
    chk("lp_no_done", seq_done, 0);
    wait_tick("lp_t5", t); chk("lp_t5_at", t - t0, 28); chk("lp_t5_ph", phase, 1);
    do_stop();
    chk("lp_stop_busy", busy, 0);
    chk("lp_stop_phase", phase, 0);
    chk("lp_stop_clr", tmr_if.timer_clr_o, 1);
    step();
    chk("lp_done_cnt", n_done - d0, 0);
    loop_en = 1'b0;

    // stop coinciding with end-of-count in phase 1
    do_start(t0);
    wait_tick("sd_t1", t);
    repeat (6) step();
    chk("sd_done_seen", tmr_if.timer_done_i, 1);
    chk("sd_en_low", tmr_if.timer_en_o, 0);
    d0 = n_tick;
    do_stop();
    chk("sd_no_tick", tick, 0);
    chk("sd_busy", busy, 0);
    chk("sd_phase", phase, 0);
    chk("sd_clr", tmr_if.timer_clr_o, 1);
    step();
    chk("sd_tick_cnt", n_tick - d0, 0);

    // table writes while in phase 1
    do_start(t0);
    wait_tick("cf_t1", t);
    cfg_write(2'd1, 8'h33); chk("cf_err_cur", cfg_err, 1);
    cfg_write(2'd2, 8'h07); chk("cf_ok_other", cfg_err, 0);
    far_addr = 3'd5;
    cfg_write(far_addr[1:0], 8'h01); chk("cf_err_far", cfg_err, 1);
    step();
    chk("cf_err_pulse", cfg_err, 0);
    wait_tick("cf_t2", t); chk("cf_t2_at", t - t0, 13);
    wait_tick("cf_t3", t); chk("cf_t3_at", t - t0, 24);
    wait_tick("cf_t4", t); chk("cf_t4_at", t - t0, 28); chk("cf_t4_done", seq_done, 1);
    step();
    do_start(t0);
    wait_tick("cf2_t1", t);
    wait_tick("cf2_t2", t); chk("cf2_ph1_len", t - t0, 13);
    wait_tick("cf2_t3", t); chk("cf2_ph2_len", t - t0, 24);
    wait_tick("cf2_t4", t);
    step();

    // pause mid-RUN on a duration-5 phase
    cfg_write(2'd0, 8'd5);
    do_start(t0);
    repeat (4) step();
    chk("pz_en_before", tmr_if.timer_en_o, 1);
    for (int i = 0; i < 7; i++) begin
      pause = 1'b1;
      #1;
      chk("pz_en_low", tmr_if.timer_en_o, 0);
      step();
    end
    pause = 1'b0;
    #1;
    chk("pz_en_resume", tmr_if.timer_en_o, 1);
    wait_tick("pz_t1", t); chk("pz_len", t - t0, 16);
    do_stop();
    step();

    // asynchronous reset mid-RUN
    do_start(t0);
    repeat (3) step();
    chk("ar_en_before", tmr_if.timer_en_o, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_en", tmr_if.timer_en_o, 0);
    chk("ar_busy", busy, 0);
    chk("ar_phase", phase, 0);
    chk("ar_clr", tmr_if.timer_clr_o, 0);
    chk("ar_value", tmr_if.timer_value_o, 0);
    step();
    rst = 1'b0;
    step();
    do_start(t0);
    step();
    chk("ar_def_value", tmr_if.timer_value_o, 8'h0a);
    wait_tick("ar_t1", t); chk("ar_def_len", t - t0, 14);
    do_stop();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
